rram_serial_rw: RTL and testbench

Parametrised serial read/write/forming engine between the register-side cache word and a bit-serial RRAM array port. It is the next generation of the single-lane 32-bit cache fill path: word width, lane count and address width are configurable, and it adds write-back, a timed forming mode, a busy/done handshake and abort on chip-enable release. It sits between the register file/cache and the top-level RRAM pad logic, which owns the tri-state buffer.

---
 rtl/rram_serial_rw.sv | 112 +++++++++++
 tb/tb_rram_serial_rw.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rram_serial_rw.sv
// rram_serial_rw: bit-serial read/write/forming engine between the cache word and an RRAM array port.
// LSB beat first; outputs decode only registered state, so requests never reach the pads combinationally.
module rram_serial_rw #(
    parameter int DATA_W      = 32,
    parameter int LANES       = 1,
    parameter int ADDR_W      = 5,
    parameter int FORM_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CE,
    input  logic              re,
    input  logic              we,
    input  logic              forming,
    input  logic [ADDR_W-1:0] cache_add,
    input  logic [DATA_W-1:0] data_register,
    output logic [DATA_W-1:0] data_cache,
    output logic              busy,
    output logic              done,
    output logic              rram_ce,
    output logic              rram_re,
    output logic              rram_we,
    output logic [ADDR_W-1:0] rram_addr,
    input  logic [LANES-1:0]  rram_data_in,
    output logic [LANES-1:0]  rram_data_out,
    output logic              rram_data_oe
);
    localparam int BEATS = DATA_W / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = FORM_CYCLES > 1 ? $clog2(FORM_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(FORM_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, READ, WRITE, FORM, DONE} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] word_q, word_d, cache_q, cache_d;
    logic              req, last;
    int                lo;

    // word_q holds the write data and doubles as the read assembly register
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        addr_d  = addr_q;
        word_d  = word_q;
        cache_d = cache_q;
        req     = !CE && (forming || we || re);
        last    = beat_q == LAST_BEAT;
        lo      = int'(beat_q) * LANES;
        if (state_q == IDLE || state_q == DONE) begin
            state_d = !req ? IDLE : forming ? FORM : we ? WRITE : READ;
            if (req) begin
                addr_d = cache_add;
                word_d = data_register;
                beat_d = '0;
                cyc_d  = '0;
            end
        end else if (CE) begin
            state_d = IDLE;
        end else if (state_q == READ) begin
            word_d[lo +: LANES] = rram_data_in;
            beat_d = beat_q + BW'(1);
            if (last) begin
                cache_d = word_d;
                state_d = DONE;
            end
        end else if (state_q == WRITE) begin
            beat_d  = beat_q + BW'(1);
            state_d = last ? DONE : WRITE;
        end else begin
            cyc_d = cyc_q + CW'(1);
            if (cyc_q == LAST_CYC) begin
                cyc_d   = '0;
                beat_d  = beat_q + BW'(1);
                state_d = last ? DONE : FORM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cyc_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            cache_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cache_q <= cache_d;
        end
    end

    assign busy          = state_q == READ || state_q == WRITE || state_q == FORM;
    assign done          = state_q == DONE;
    assign rram_ce       = !busy;
    assign rram_re       = state_q == READ;
    assign rram_we       = state_q == WRITE || state_q == FORM;
    assign rram_data_oe  = rram_we;
    assign rram_addr     = addr_q;
    assign data_cache    = cache_q;
    assign rram_data_out = state_q == FORM ? '1 : state_q == WRITE ? word_q[lo +: LANES] : '0;
endmodule

// File: tb/tb_rram_serial_rw.sv
// tb_rram_serial_rw: directed scoreboard bench for a 1-lane and a 4-lane rram_serial_rw.
// Stimulus pushes expected done words and pad beats; a negedge monitor pops and compares them.
module tb_rram_serial_rw;
    logic        clk = 0;
    logic        rst = 1;
    logic        ce1 = 0, ce4 = 0, re = 1, we = 0, forming = 0;
    logic [4:0]  addr = 0;
    logic [31:0] wdata = 0;
    logic [0:0]  din1 = 0;
    logic [3:0]  din4 = 0;

    logic [31:0] cache1, cache4;
    logic        busy1, busy4, done1, done4, rce1, rce4, rre1, rre4, rwe1, rwe4, oe1, oe4;
    logic [4:0]  raddr1, raddr4;
    logic [0:0]  dout1;
    logic [3:0]  dout4;

    int nvec = 0, nerr = 0, re_cnt1 = 0;
    logic [31:0] q_done1[$], q_done4[$];
    logic [1:0]  q_out1[$];
    logic [4:0]  q_out4[$];

    always #5 clk = ~clk;

    rram_serial_rw #(.DATA_W(32), .LANES(1), .ADDR_W(5), .FORM_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .CE(ce1), .re(re), .we(we), .forming(forming),
        .cache_add(addr), .data_register(wdata), .data_cache(cache1), .busy(busy1),
        .done(done1), .rram_ce(rce1), .rram_re(rre1), .rram_we(rwe1), .rram_addr(raddr1),
        .rram_data_in(din1), .rram_data_out(dout1), .rram_data_oe(oe1));

    rram_serial_rw #(.DATA_W(32), .LANES(4), .ADDR_W(5), .FORM_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .CE(ce4), .re(re), .we(we), .forming(forming),
        .cache_add(addr), .data_register(wdata), .data_cache(cache4), .busy(busy4),
        .done(done4), .rram_ce(rce4), .rram_re(rre4), .rram_we(rwe4), .rram_addr(raddr4),
        .rram_data_in(din4), .rram_data_out(dout4), .rram_data_oe(oe4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rre1) re_cnt1++;
        if (done1) begin
            if (q_done1.size() == 0) chk("u1 unexpected done", {31'b0, done1}, 0);
            else chk("u1 data_cache at done", cache1, q_done1.pop_front());
        end
        if (done4) begin
            if (q_done4.size() == 0) chk("u4 unexpected done", {31'b0, done4}, 0);
            else chk("u4 data_cache at done", cache4, q_done4.pop_front());
        end
        if (oe1) begin
            if (q_out1.size() == 0) chk("u1 unexpected oe", {31'b0, oe1}, 0);
            else chk("u1 we/data_out beat", {30'b0, rwe1, dout1}, {30'b0, q_out1.pop_front()});
        end
        if (oe4) begin
            if (q_out4.size() == 0) chk("u4 unexpected oe", {31'b0, oe4}, 0);
            else chk("u4 we/data_out beat", {27'b0, rwe4, dout4}, {27'b0, q_out4.pop_front()});
        end
    end

    task automatic read1(input logic [31:0] w);
        for (int i = 0; i < 32; i++) begin
            din1 = w[i];
            tick;
        end
    endtask

    initial begin
        logic [31:0] w;
        tick;
        chk("busy1 during rst", {31'b0, busy1}, 0);
        tick;
        chk("busy1 after rst", {31'b0, busy1}, 0);
        chk("busy4 after rst", {31'b0, busy4}, 0);
        chk("done1 rst", {31'b0, done1}, 0);
        chk("rram_ce1 rst", {31'b0, rce1}, 1);
        chk("rram_ce4 rst", {31'b0, rce4}, 1);
        chk("rram_re1 rst", {31'b0, rre1}, 0);
        chk("rram_we1 rst", {31'b0, rwe1}, 0);
        chk("oe1 rst", {31'b0, oe1}, 0);
        chk("data_out4 rst", {28'b0, dout4}, 0);
        chk("addr1 rst", {27'b0, raddr1}, 0);
        chk("data_cache1 rst", cache1, 0);
        chk("data_cache4 rst", cache4, 0);
        rst = 0;
        re = 0;

        // single-lane read
        ce4 = 1;
        w = 32'hDB6DB6DB;
        q_done1.push_back(w);
        re_cnt1 = 0;
        addr = 5'd5;
        re = 1;
        tick;
        re = 0;
        addr = 0;
        chk("read busy1", {31'b0, busy1}, 1);
        chk("read rram_ce1", {31'b0, rce1}, 0);
        chk("read addr1", {27'b0, raddr1}, 5);
        read1(w);
        chk("read done1", {31'b0, done1}, 1);
        chk("read rram_re cycles", re_cnt1, 32);
        tick;

        // four-lane read then write
        ce1 = 1;
        ce4 = 0;
        w = 32'hCAFEF00D;
        q_done4.push_back(w);
        re = 1;
        tick;
        re = 0;
        for (int i = 0; i < 8; i++) begin
            din4 = w[i*4 +: 4];
            tick;
        end
        chk("u4 read done", {31'b0, done4}, 1);
        tick;
        wdata = 32'h12345678;
        for (int i = 8; i >= 1; i--) q_out4.push_back({1'b1, 4'(i)});
        q_done4.push_back(32'hCAFEF00D);
        addr = 5'd9;
        we = 1;
        tick;
        we = 0;
        addr = 0;
        chk("write addr4", {27'b0, raddr4}, 9);
        repeat (8) tick;
        chk("write done4", {31'b0, done4}, 1);
        chk("write busy4 in done", {31'b0, busy4}, 0);
        tick;

        // re and we together: write wins
        ce4 = 1;
        ce1 = 0;
        w = 32'hA5A50F0F;
        wdata = w;
        for (int i = 0; i < 32; i++) q_out1.push_back({1'b1, w[i]});
        q_done1.push_back(32'hDB6DB6DB);
        re = 1;
        we = 1;
        tick;
        re = 0;
        we = 0;
        chk("re+we no rram_re", {31'b0, rre1}, 0);
        repeat (32) tick;
        chk("write1 done", {31'b0, done1}, 1);
        tick;

        // forming beats forming+we
        for (int i = 0; i < 128; i++) q_out1.push_back(2'b11);
        q_done1.push_back(32'hDB6DB6DB);
        forming = 1;
        we = 1;
        tick;
        forming = 0;
        we = 0;
        repeat (127) tick;
        chk("form still busy at cycle 128", {31'b0, busy1}, 1);
        tick;
        chk("form done", {31'b0, done1}, 1);
        tick;

        // CE abort during read beat 10
        re = 1;
        tick;
        re = 0;
        for (int i = 0; i < 10; i++) begin
            din1 = 1;
            tick;
        end
        ce1 = 1;
        tick;
        chk("abort busy1", {31'b0, busy1}, 0);
        chk("abort rram_re1", {31'b0, rre1}, 0);
        chk("abort done1", {31'b0, done1}, 0);
        chk("abort data_cache1", cache1, 32'hDB6DB6DB);
        repeat (3) tick;
        ce1 = 0;

        // reset mid-write on the 4-lane engine
        ce1 = 1;
        ce4 = 0;
        wdata = 32'hFFFFFFFF;
        repeat (3) q_out4.push_back(5'h1F);
        we = 1;
        tick;
        we = 0;
        tick;
        tick;
        rst = 1;
        tick;
        chk("rst mid-write oe4", {31'b0, oe4}, 0);
        chk("rst mid-write busy4", {31'b0, busy4}, 0);
        chk("rst mid-write data_cache4", cache4, 0);
        rst = 0;
        tick;

        // back-to-back reads with re held
        ce4 = 1;
        ce1 = 0;
        q_done1.push_back(32'h13579BDF);
        q_done1.push_back(32'h2468ACE0);
        re = 1;
        tick;
        read1(32'h13579BDF);
        chk("b2b first done", {31'b0, done1}, 1);
        chk("b2b busy in done", {31'b0, busy1}, 0);
        tick;
        chk("b2b second busy", {31'b0, busy1}, 1);
        chk("b2b second rram_re", {31'b0, rre1}, 1);
        re = 0;
        read1(32'h2468ACE0);
        chk("b2b second done", {31'b0, done1}, 1);
        tick;
        tick;

        chk("u1 done queue drained", q_done1.size(), 0);
        chk("u4 done queue drained", q_done4.size(), 0);
        chk("u1 beat queue drained", q_out1.size(), 0);
        chk("u4 beat queue drained", q_out4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
